// File: rtl/count_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_dec_pkg
//  Purpose  : Shared types for the count step decoder. These are the decoder
//             state and the classification of one counter-value delta.
//  Revision : 1.0  initial release
// ============================================================================
package count_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } dec_state_t;

    typedef enum logic [2:0] {
        CL_HOLD      = 3'd0,
        CL_UP        = 3'd1,
        CL_DOWN      = 3'd2,
        CL_ZERO_JUMP = 3'd3,
        CL_ILLEGAL   = 3'd4
    } step_class_t;

    // A delta is legal when a real counter could have produced it.
    function automatic logic is_legal(input step_class_t c);
        return (c == CL_HOLD) || (c == CL_UP) || (c == CL_DOWN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_step_classify.sv
`default_nettype none
// ============================================================================
//  Module   : count_step_classify
//  Purpose  : Combinational classifier for the delta (count_in - prev) mod 2^W.
//             When COUNT_STEP_DECODER_RESET_DETECT_EN is defined, a non-step
//             jump to zero is reported as ZERO_JUMP.
//  Revision : 1.0  initial release
// ============================================================================
module count_step_classify
    import count_dec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_count,
    output step_class_t      o_class
);

    logic [WIDTH-1:0] w_delta;

    assign w_delta = i_count - i_prev;

    // Steps take precedence, so a wrap to 0 from all-ones is still UP.
    always_comb begin
        o_class = CL_ILLEGAL;
        if (w_delta == '0) begin
            o_class = CL_HOLD;
        end else if (w_delta == WIDTH'(1)) begin
            o_class = CL_UP;
        end else if (&w_delta) begin
            o_class = CL_DOWN;
`ifdef COUNT_STEP_DECODER_RESET_DETECT_EN
        end else if (i_count == '0) begin
            o_class = CL_ZERO_JUMP;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/count_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : count_step_decoder
//  Purpose  : Recovers hold/up/down steps from a sampled counter value stream.
//             It tracks lock and flags impossible deltas. It also keeps a
//             saturating error tally.
//             Optional: COUNT_STEP_DECODER_RESET_DETECT_EN enables detection
//             of counter resets (jump to 0) as a separate, non-error event.
//  Revision : 1.0  initial release
// ============================================================================
module count_step_decoder
    import count_dec_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 2,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 count_valid,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 err_clr,
    output logic                 step_valid,
    output logic                 step_enable,
    output logic                 step_direction,
    output logic                 locked,
    output logic                 error,
    output logic                 reset_seen,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int LRUN_W = $clog2(LOCK_COUNT + 1);
    localparam int BRUN_W = $clog2(LOSS_COUNT + 1);

    localparam logic [LRUN_W-1:0] c_lock_last = LRUN_W'(LOCK_COUNT - 1);
    localparam logic [BRUN_W-1:0] c_loss_last = BRUN_W'(LOSS_COUNT - 1);

    dec_state_t           state_q,      state_d;
    logic [WIDTH-1:0]     prev_q,       prev_d;
    logic [LRUN_W-1:0]    legal_run_q,  legal_run_d;
    logic [BRUN_W-1:0]    bad_run_q,    bad_run_d;
    logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;
    logic                 step_valid_q, step_valid_d;
    logic                 step_en_q,    step_en_d;
    logic                 step_dir_q,   step_dir_d;
    logic                 locked_q,     locked_d;
    logic                 error_q,      error_d;
    logic                 rst_seen_q,   rst_seen_d;

    step_class_t w_class;
    logic        w_legal;
    logic        w_zero;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_prev  (prev_q),
        .i_count (count_in),
        .o_class (w_class)
    );

    assign w_legal = is_legal(w_class);
    assign w_zero  = (w_class == CL_ZERO_JUMP);

    // Next-state, run counters, registered pulses and error tally.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        legal_run_d  = legal_run_q;
        bad_run_d    = bad_run_q;
        err_count_d  = err_count_q;
        step_valid_d = 1'b0;
        step_en_d    = 1'b0;
        step_dir_d   = 1'b0;
        error_d      = 1'b0;
        rst_seen_d   = 1'b0;

        if (count_valid) begin
            prev_d = count_in;
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_ACQ;
                    legal_run_d = '0;
                end
                ST_ACQ: begin
                    if (w_legal) begin
                        if (legal_run_q == c_lock_last) begin
                            state_d     = ST_LOCKED;
                            legal_run_d = '0;
                            bad_run_d   = '0;
                        end else begin
                            legal_run_d = legal_run_q + 1'b1;
                        end
                    end else begin
                        legal_run_d = '0;
                        rst_seen_d  = w_zero;
                        if (w_zero) begin
                            bad_run_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_legal) begin
                        step_valid_d = 1'b1;
                        step_en_d    = (w_class != CL_HOLD);
                        step_dir_d   = (w_class == CL_UP);
                        bad_run_d    = '0;
                    end else if (w_zero) begin
                        rst_seen_d = 1'b1;
                        bad_run_d  = '0;
                    end else begin
                        error_d = 1'b1;
                        if (bad_run_q == c_loss_last) begin
                            state_d     = ST_ACQ;
                            legal_run_d = '0;
                            bad_run_d   = '0;
                        end else begin
                            bad_run_d = bad_run_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (error_d && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
        // Clear has priority over a same-cycle increment.
        if (err_clr) begin
            err_count_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // All state and outputs are registered; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            legal_run_q  <= '0;
            bad_run_q    <= '0;
            err_count_q  <= '0;
            step_valid_q <= 1'b0;
            step_en_q    <= 1'b0;
            step_dir_q   <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            rst_seen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            legal_run_q  <= legal_run_d;
            bad_run_q    <= bad_run_d;
            err_count_q  <= err_count_d;
            step_valid_q <= step_valid_d;
            step_en_q    <= step_en_d;
            step_dir_q   <= step_dir_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            rst_seen_q   <= rst_seen_d;
        end
    end

    assign step_valid     = step_valid_q;
    assign step_enable    = step_en_q;
    assign step_direction = step_dir_q;
    assign locked         = locked_q;
    assign error          = error_q;
    // Without reset detection no ZERO_JUMP exists, so this flop stays at 0.
    assign reset_seen     = rst_seen_q;
    assign err_count      = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_step_decoder
//  Purpose  : Self-checking bench for count_step_decoder. It runs directed
//             scenarios and then a randomized stream. Every output is
//             compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_step_decoder;

    localparam int LOCK = 2;
    localparam int LOSS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       count_valid = 1'b0;
    logic [7:0] count_in = 8'd0;
    logic       err_clr = 1'b0;
    logic       step_valid, step_enable, step_direction, locked, error, reset_seen;
    logic [3:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [7:0] m_prev;
    bit         m_started, m_locked;
    int         m_lrun, m_brun;
    bit         e_sv, e_se, e_sd, e_err, e_rs;
    logic [3:0] e_cnt;

    count_step_decoder #(
        .WIDTH      (8),
        .LOCK_COUNT (LOCK),
        .LOSS_COUNT (LOSS),
        .ERR_CNT_W  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .count_valid    (count_valid),
        .count_in       (count_in),
        .err_clr        (err_clr),
        .step_valid     (step_valid),
        .step_enable    (step_enable),
        .step_direction (step_direction),
        .locked         (locked),
        .error          (error),
        .reset_seen     (reset_seen),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 8'd0; m_started = 0; m_locked = 0; m_lrun = 0; m_brun = 0;
        e_sv = 0; e_se = 0; e_sd = 0; e_err = 0; e_rs = 0; e_cnt = 4'd0;
    endtask

    // Reference behaviour, applied at each rising edge.
    task automatic model_step(input bit v, input logic [7:0] x, input bit clr);
        logic [7:0] d;
        bit         legal, zj;
        e_sv = 0; e_se = 0; e_sd = 0; e_err = 0; e_rs = 0;
        if (v) begin
            d     = x - m_prev;
            legal = (d == 8'd0) || (d == 8'd1) || (d == 8'hFF);
`ifdef COUNT_STEP_DECODER_RESET_DETECT_EN
            zj = !legal && (x == 8'd0);
`else
            zj = 0;
`endif
            if (!m_started) begin
                m_started = 1; m_lrun = 0;
            end else if (!m_locked) begin
                if (legal) begin
                    m_lrun++;
                    if (m_lrun >= LOCK) begin m_locked = 1; m_brun = 0; end
                end else begin
                    m_lrun = 0;
                    if (zj) begin e_rs = 1; m_brun = 0; end
                end
            end else begin
                if (legal) begin
                    e_sv = 1; e_se = (d != 8'd0); e_sd = (d == 8'd1); m_brun = 0;
                end else if (zj) begin
                    e_rs = 1; m_brun = 0;
                end else begin
                    e_err = 1;
                    if (e_cnt != 4'hF) e_cnt = e_cnt + 4'd1;
                    m_brun++;
                    if (m_brun >= LOSS) begin m_locked = 0; m_lrun = 0; m_brun = 0; end
                end
            end
            m_prev = x;
        end
        if (clr) e_cnt = 4'd0;
    endtask

    task automatic check_all();
        check_eq("step_valid", step_valid, e_sv);
        check_eq("step_enable", step_enable, e_se);
        check_eq("step_direction", step_direction, e_sd);
        check_eq("locked", locked, m_locked);
        check_eq("error", error, e_err);
        check_eq("reset_seen", reset_seen, e_rs);
        check_eq("err_count", err_count, e_cnt);
    endtask

    task automatic cycle(input bit v, input logic [7:0] x, input bit clr);
        count_valid = v; count_in = x; err_clr = clr;
        @(posedge clk);
        model_step(v, x, clr);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [7:0] x);
        cycle(1'b1, x, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges, then lock at value v.
    task automatic relock(input logic [7:0] v);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        feed(v - 8'd2);
        feed(v - 8'd1);
        feed(v);
        check_eq("relock_locked", locked, 1'b1);
    endtask

    initial begin
        logic [7:0] v;
        int         r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_locked", locked, 1'b0);
        check_eq("reset_errcnt", err_count, 4'd0);
        check_all();
        rst_n = 1'b1;

        // Stream 10..13: lock after 12, step up on 13.
        feed(8'd10);
        check_eq("first_sample_no_pulse", step_valid, 1'b0);
        feed(8'd11);
        check_eq("acq_not_locked", locked, 1'b0);
        feed(8'd12);
        check_eq("t1_locked", locked, 1'b1);
        feed(8'd13);
        check_eq("t1_sv", step_valid, 1'b1);
        check_eq("t1_se", step_enable, 1'b1);
        check_eq("t1_sd", step_direction, 1'b1);

        // Wrap behaviour around 255/0.
        relock(8'd254);
        feed(8'd255); check_eq("t2_up_dir", step_direction, 1'b1);
        feed(8'd0);   check_eq("t2_wrap_up", {step_valid, step_enable, step_direction}, 3'b111);
        feed(8'd255); check_eq("t2_wrap_dn", {step_valid, step_enable, step_direction}, 3'b110);
        feed(8'd255); check_eq("t2_hold", {step_valid, step_enable, step_direction}, 3'b100);

        // Loss of lock after three illegal deltas, then relock.
        relock(8'd50);
        feed(8'd60); check_eq("t3_err1", error, 1'b1);
        feed(8'd70); check_eq("t3_err2", error, 1'b1);
        feed(8'd80); check_eq("t3_err3", error, 1'b1);
        check_eq("t3_cnt", err_count, 4'd3);
        check_eq("t3_unlocked", locked, 1'b0);
        feed(8'd81);
        feed(8'd82); check_eq("t3_relock", locked, 1'b1);

        // Jump to zero while locked.
        relock(8'd100);
        feed(8'd0);
`ifdef COUNT_STEP_DECODER_RESET_DETECT_EN
        check_eq("t4_rs", reset_seen, 1'b1);
        check_eq("t4_noerr", error, 1'b0);
        check_eq("t4_locked", locked, 1'b1);
`else
        check_eq("t4_err", error, 1'b1);
        check_eq("t4_cnt", err_count, 4'd1);
        check_eq("t4_rs0", reset_seen, 1'b0);
`endif

        // Clear wins over a same-cycle increment.
        relock(8'd100);
        cycle(1'b1, 8'd7, 1'b1);
        check_eq("t5_clr_err", error, 1'b1);
        check_eq("t5_clr_cnt", err_count, 4'd0);

        // Saturation of the error tally.
        relock(8'd10);
        v = 8'd10;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 3; j++) begin
                v = v + 8'd50;
                if (v == 8'd0) v = 8'd3;
                feed(v);
            end
            feed(v + 8'd1);
            feed(v + 8'd2);
            v = v + 8'd2;
            if (k == 4) check_eq("t5_sat15", err_count, 4'hF);
        end
        check_eq("t5_sat_hold", err_count, 4'hF);

        // Async reset mid-stream while locked.
        relock(8'd30);
        feed(8'd31);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_locked", locked, 1'b0);
        check_eq("t6_async_sv", step_valid, 1'b0);
        check_eq("t6_async_cnt", err_count, 4'd0);
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
        feed(8'd40);
        check_eq("t6_first_no_pulse", {step_valid, error, reset_seen, locked}, 4'b0000);

        // Randomized stream against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      v = m_prev;
            else if (r < 55) v = m_prev + 8'd1;
            else if (r < 80) v = m_prev - 8'd1;
            else if (r < 88) v = 8'd0;
            else             v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 399) == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                rst_n = 1'b1;
            end
            cycle($urandom_range(0, 99) < 85, v, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
